// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - arbitrates WB, MUU and DBG onto the single register-bank write port
//
// Ports:
//   clock, reset_n            single clock, asynchronous active-low reset
//   wb_*                      writeback request (mode 01 unconditional, 10 conditional, 00 none)
//   wb_stall                  registered; asks the pipeline to hold WB so a starved MUU result can drain
//   muu_* / muu_ready         multiply/divide result stream, always unconditional
//   dbg_* / dbg_ready         debug loader stream, always unconditional, lowest priority
//   muu_issue, muu_issue_reg  MUU op issued toward a destination (scoreboard only)
//   rd_reg1/2, hazard1/2      decode sources and their pending-MUU hazard flags
//   write_*, movn             registered bank write port
//
// Build option: REGFILE_SCOREBOARD_EN enables the 32-entry busy mask behind hazard1/hazard2.

module regfile_write_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic [1:0]  wb_mode,
    input  logic        wb_muu_we,
    input  logic        wb_movn,
    output logic        wb_stall,
    input  logic        muu_valid,
    output logic        muu_ready,
    input  logic [4:0]  muu_reg,
    input  logic [31:0] muu_data,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic [4:0]  dbg_reg,
    input  logic [31:0] dbg_data,
    input  logic        muu_issue,
    input  logic [4:0]  muu_issue_reg,
    input  logic [4:0]  rd_reg1,
    input  logic [4:0]  rd_reg2,
    output logic        hazard1,
    output logic        hazard2,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic [1:0]  write_enable,
    output logic        muu_write_enable,
    output logic        movn
);

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

    logic        wb_xfer;
    logic        muu_xfer;
    logic        dbg_xfer;
    logic        starve_inc;
    logic [3:0]  starve_cnt;

    logic        win;
    logic [4:0]  sel_reg;
    logic [31:0] sel_data;
    logic [1:0]  sel_we;
    logic        sel_muu_we;
    logic        sel_movn;

    // A WB request presented during a stall is a protocol error and is simply
    // dropped; the stall cycle belongs to MUU.
    assign muu_ready  = !wb_valid || wb_stall;
    assign dbg_ready  = !wb_valid && !muu_valid;
    assign wb_xfer    = wb_valid && !wb_stall;
    assign muu_xfer   = muu_valid && muu_ready;
    assign dbg_xfer   = dbg_valid && dbg_ready;
    assign starve_inc = muu_valid && !muu_xfer;

    always_comb begin
        win        = 1'b0;
        sel_reg    = write_reg;
        sel_data   = write_data;
        sel_we     = 2'b00;
        sel_muu_we = 1'b0;
        sel_movn   = 1'b0;
        if (wb_xfer) begin
            win        = 1'b1;
            sel_reg    = wb_reg;
            sel_data   = wb_data;
            sel_we     = wb_mode;
            sel_muu_we = wb_muu_we;
            sel_movn   = wb_movn;
        end else if (muu_xfer) begin
            win      = 1'b1;
            sel_reg  = muu_reg;
            sel_data = muu_data;
            sel_we   = 2'b01;
        end else if (dbg_xfer) begin
            win      = 1'b1;
            sel_reg  = dbg_reg;
            sel_data = dbg_data;
            sel_we   = 2'b01;
        end
    end

    // Register 0 is handshaken like any other destination but never enabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_reg        <= 5'd0;
            write_data       <= 32'd0;
            write_enable     <= 2'b00;
            muu_write_enable <= 1'b0;
            movn             <= 1'b0;
        end else if (win) begin
            write_reg        <= sel_reg;
            write_data       <= sel_data;
            write_enable     <= (sel_reg == 5'd0) ? 2'b00 : sel_we;
            muu_write_enable <= sel_muu_we;
            movn             <= sel_movn;
        end else begin
            write_enable     <= 2'b00;
            muu_write_enable <= 1'b0;
            movn             <= 1'b0;
        end
    end

    // The counter never passes STARVE_LIMIT: the stall it raises forces the
    // MUU transfer on the very next cycle, which clears it again.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 4'd0;
            wb_stall   <= 1'b0;
        end else begin
            starve_cnt <= starve_inc ? starve_cnt + 4'd1 : 4'd0;
            wb_stall   <= (starve_cnt == STARVE_LAST) && starve_inc;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [31:0] busy;
    logic [31:0] busy_next;

    // Clear first, then set, so a same-edge issue to the retiring register wins.
    always_comb begin
        busy_next = busy;
        if (muu_xfer) begin
            busy_next[muu_reg] = 1'b0;
        end
        if (muu_issue && (muu_issue_reg != 5'd0)) begin
            busy_next[muu_issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_next;
        end
    end

    assign hazard1 = (rd_reg1 != 5'd0) && busy[rd_reg1];
    assign hazard2 = (rd_reg2 != 5'd0) && busy[rd_reg2];
`else
    logic unused_sb;
    assign unused_sb = &{1'b0, muu_issue, muu_issue_reg, rd_reg1, rd_reg2};
    assign hazard1   = 1'b0;
    assign hazard2   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - directed vector bench for regfile_write_scheduler

module tb_regfile_write_scheduler;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic [1:0]  wb_mode = '0;
    logic        wb_muu_we = 1'b0;
    logic        wb_movn = 1'b0;
    logic        wb_stall;
    logic        muu_valid = 1'b0;
    logic        muu_ready;
    logic [4:0]  muu_reg = '0;
    logic [31:0] muu_data = '0;
    logic        dbg_valid = 1'b0;
    logic        dbg_ready;
    logic [4:0]  dbg_reg = '0;
    logic [31:0] dbg_data = '0;
    logic        muu_issue = 1'b0;
    logic [4:0]  muu_issue_reg = '0;
    logic [4:0]  rd_reg1 = '0;
    logic [4:0]  rd_reg2 = '0;
    logic        hazard1;
    logic        hazard2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [1:0]  write_enable;
    logic        muu_write_enable;
    logic        movn;

    int checks = 0;
    int errors = 0;

    regfile_write_scheduler #(.STARVE_LIMIT(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_mode(wb_mode),
        .wb_muu_we(wb_muu_we), .wb_movn(wb_movn), .wb_stall(wb_stall),
        .muu_valid(muu_valid), .muu_ready(muu_ready), .muu_reg(muu_reg), .muu_data(muu_data),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_reg(dbg_reg), .dbg_data(dbg_data),
        .muu_issue(muu_issue), .muu_issue_reg(muu_issue_reg),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .hazard1(hazard1), .hazard2(hazard2),
        .write_reg(write_reg), .write_data(write_data), .write_enable(write_enable),
        .muu_write_enable(muu_write_enable), .movn(movn)
    );

    always #5 clock = ~clock;

    // Reference bank: unconditional writes on 01, conditional (10) only when a flag is set.
    logic [31:0] bank [32];
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 32; r++) bank[r] <= 32'd0;
        end else if (write_reg != 5'd0 &&
                     (write_enable == 2'b01 ||
                      (write_enable == 2'b10 && (muu_write_enable || movn)))) begin
            bank[write_reg] <= write_data;
        end
    end

    typedef struct {
        logic        wb_valid;
        logic [4:0]  wb_reg;
        logic [31:0] wb_data;
        logic [1:0]  wb_mode;
        logic        wb_muu_we;
        logic        wb_movn;
        logic        muu_valid;
        logic [4:0]  muu_reg;
        logic [31:0] muu_data;
        logic        dbg_valid;
        logic [4:0]  dbg_reg;
        logic [31:0] dbg_data;
        logic        exp_muu_ready;
        logic        exp_dbg_ready;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        logic [1:0]  exp_we;
        logic        exp_muu_we;
        logic        exp_movn;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_mode = 2'b00; wb_muu_we = 1'b0; wb_movn = 1'b0;
        muu_valid = 1'b0; dbg_valid = 1'b0; muu_issue = 1'b0;
    endtask

    logic sb_exp;

    initial begin
`ifdef REGFILE_SCOREBOARD_EN
        sb_exp = 1'b1;
`else
        sb_exp = 1'b0;
`endif
        //          wb: v  reg    data          mode   mwe   movn   muu: v reg data        dbg: v reg data           rdy: muu dbg  exp: reg data          we    mwe   movn
        vecs[0] = '{1'b1, 5'd8,  32'h1234, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 5'd8,  32'h1234, 2'b01, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,    2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  1'b1, 1'b1, 5'd8,  32'h1234, 2'b00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,    2'b00, 1'b0, 1'b0, 1'b1, 5'd9, 32'hAA, 1'b0, 5'd0,  32'h0,  1'b1, 1'b0, 5'd9,  32'hAA,   2'b01, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,    2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd10, 32'hBB, 1'b1, 1'b1, 5'd10, 32'hBB,   2'b01, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 5'd0,  32'hFFFF, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 5'd0,  32'hFFFF, 2'b00, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 5'd11, 32'h55,   2'b10, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 5'd11, 32'h55,   2'b10, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 5'd11, 32'h77,   2'b10, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 5'd11, 32'h77,   2'b10, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 5'd12, 32'h99,   2'b01, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 5'd12, 32'h99,   2'b01, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 5'd13, 32'h42,   2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 1'b0, 5'd13, 32'h42,   2'b00, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 5'd3,  32'h3,    2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd4,  32'h44, 1'b0, 1'b0, 5'd3,  32'h3,    2'b01, 1'b0, 1'b0};

        // Reset state
        step();
        step();
        check("rst_write_enable", 32'(write_enable), 32'd0);
        check("rst_write_reg", 32'(write_reg), 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_flags", {30'd0, muu_write_enable, movn}, 32'd0);
        check("rst_wb_stall", 32'(wb_stall), 32'd0);
        check("rst_hazards", {30'd0, hazard1, hazard2}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // Single-cycle vectors
        for (int i = 0; i < 10; i++) begin
            wb_valid = vecs[i].wb_valid; wb_reg = vecs[i].wb_reg; wb_data = vecs[i].wb_data;
            wb_mode = vecs[i].wb_mode; wb_muu_we = vecs[i].wb_muu_we; wb_movn = vecs[i].wb_movn;
            muu_valid = vecs[i].muu_valid; muu_reg = vecs[i].muu_reg; muu_data = vecs[i].muu_data;
            dbg_valid = vecs[i].dbg_valid; dbg_reg = vecs[i].dbg_reg; dbg_data = vecs[i].dbg_data;
            #1;
            check($sformatf("v%0d_muu_ready", i), 32'(muu_ready), 32'(vecs[i].exp_muu_ready));
            check($sformatf("v%0d_dbg_ready", i), 32'(dbg_ready), 32'(vecs[i].exp_dbg_ready));
            step();
            check($sformatf("v%0d_write_reg", i), 32'(write_reg), 32'(vecs[i].exp_reg));
            check($sformatf("v%0d_write_data", i), write_data, vecs[i].exp_data);
            check($sformatf("v%0d_write_enable", i), 32'(write_enable), 32'(vecs[i].exp_we));
            check($sformatf("v%0d_muu_we", i), 32'(muu_write_enable), 32'(vecs[i].exp_muu_we));
            check($sformatf("v%0d_movn", i), 32'(movn), 32'(vecs[i].exp_movn));
            if (i == 1) check("bank_r8_after_commit", bank[8], 32'h1234);
        end
        idle_inputs();
        step();
        check("bank_r0_stays_zero", bank[0], 32'd0);
        check("bank_r11_cond_no_flags", bank[11], 32'h55);

        // WB, MUU and DBG together: WB, then MUU, then DBG
        wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'h11; wb_mode = 2'b01;
        muu_valid = 1'b1; muu_reg = 5'd9; muu_data = 32'hAA;
        dbg_valid = 1'b1; dbg_reg = 5'd10; dbg_data = 32'hBB;
        #1;
        check("all3_dbg_ready", 32'(dbg_ready), 32'd0);
        step();
        check("all3_wb_wins", 32'(write_reg), 32'd7);
        wb_valid = 1'b0;
        #1;
        check("all3_dbg_ready_muu_pending", 32'(dbg_ready), 32'd0);
        step();
        check("all3_muu_second", write_data, 32'hAA);
        muu_valid = 1'b0;
        #1;
        check("all3_dbg_ready_free", 32'(dbg_ready), 32'd1);
        step();
        check("all3_dbg_third", {write_data[15:0], 11'd0, write_reg}, {16'hBB, 11'd0, 5'd10});
        idle_inputs();
        step();

        // Starvation: WB every cycle while MUU waits
        muu_valid = 1'b1; muu_reg = 5'd14; muu_data = 32'hCC;
        wb_mode = 2'b01;
        for (int c = 0; c < 4; c++) begin
            wb_valid = 1'b1; wb_reg = 5'(20 + c); wb_data = 32'(c);
            #1;
            check($sformatf("starve_c%0d_stall", c), 32'(wb_stall), 32'd0);
            check($sformatf("starve_c%0d_muu_ready", c), 32'(muu_ready), 32'd0);
            step();
            check($sformatf("starve_c%0d_wb_reg", c), 32'(write_reg), 32'(20 + c));
        end
        check("starve_stall_high", 32'(wb_stall), 32'd1);
        wb_valid = 1'b0;
        #1;
        check("starve_muu_ready_in_stall", 32'(muu_ready), 32'd1);
        step();
        check("starve_muu_granted", {write_data[15:0], 11'd0, write_reg}, {16'hCC, 11'd0, 5'd14});
        check("starve_stall_low", 32'(wb_stall), 32'd0);
        idle_inputs();
        step();

        // Reset mid-request must drop the accumulated wait count
        wb_valid = 1'b1; wb_reg = 5'd5; muu_valid = 1'b1;
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("midrst_write_enable", 32'(write_enable), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("midrst_c%0d_stall", c), 32'(wb_stall), 32'd0);
        end
        wb_valid = 1'b0;
        step();
        idle_inputs();
        step();

        // Scoreboard hazards
        rd_reg1 = 5'd12; rd_reg2 = 5'd0;
        muu_issue = 1'b1; muu_issue_reg = 5'd12;
        step();
        muu_issue = 1'b0;
        check("sb_issue_hazard1", 32'(hazard1), 32'(sb_exp));
        check("sb_rd0_hazard2", 32'(hazard2), 32'd0);
        rd_reg2 = 5'd12;
        #1;
        check("sb_issue_hazard2", 32'(hazard2), 32'(sb_exp));
        muu_valid = 1'b1; muu_reg = 5'd12; muu_data = 32'hDD;
        muu_issue = 1'b1; muu_issue_reg = 5'd12;
        step();
        check("sb_set_wins_reg", 32'(write_reg), 32'd12);
        check("sb_set_wins_hazard", 32'(hazard1), 32'(sb_exp));
        muu_issue = 1'b0;
        step();
        muu_valid = 1'b0;
        check("sb_clear_hazard", 32'(hazard1), 32'd0);
        check("sb_clear_data", write_data, 32'hDD);
        muu_issue = 1'b1; muu_issue_reg = 5'd0; rd_reg1 = 5'd0;
        step();
        muu_issue = 1'b0;
        check("sb_r0_no_hazard", 32'(hazard1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Shares the single write port of the 32×32 register bank between three writers: the pipeline writeback stage (WB), the multiply/divide unit (MUU) result path and the debug loader (DBG). Grants one writer per cycle and registers the winning write onto the bank's write controls (`write_reg`, `write_data`, `write_enable[1:0]`, `muu_write_enable`, `movn`). Bounds MUU starvation by stalling WB. Optionally tracks outstanding MUU destinations for hazard detection.

## Interface
- `STARVE_LIMIT`, 4: consecutive cycles MUU may wait with `muu_valid` high before WB is stalled; legal range 1..15.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wb_valid` in 1: WB write request; always accepted unless `wb_stall` is 1.
- `wb_reg` in 5, `wb_data` in 32: WB destination and data.
- `wb_mode` in 2: 01 unconditional; 10 conditional; 00 no write.
- `wb_muu_we` in 1, `wb_movn` in 1: condition flags carried with WB.
- `wb_stall` out 1: registered; pipeline must hold WB and drive `wb_valid`=0 while high.
- `muu_valid` in 1, `muu_ready` out 1 (combinational), `muu_reg` in 5, `muu_data` in 32: MUU result, always unconditional.
- `dbg_valid` in 1, `dbg_ready` out 1 (combinational), `dbg_reg` in 5, `dbg_data` in 32: debug write, always unconditional.
- `muu_issue` in 1, `muu_issue_reg` in 5: MUU op issued with this destination.
- `rd_reg1` in 5, `rd_reg2` in 5: decode-stage source registers.
- `hazard1` out 1, `hazard2` out 1: source is busy with a pending MUU write.
- `write_reg` out 5, `write_data` out 32, `write_enable` out 2, `muu_write_enable` out 1, `movn` out 1: registered bank write port.

## Operation
- Priority per cycle:
  - WB if `wb_valid` is 1 (only possible while `wb_stall` is 0).
  - Otherwise MUU if `muu_valid` is 1.
  - Otherwise DBG if `dbg_valid` is 1.
- `muu_ready` = !`wb_valid` || `wb_stall`. `dbg_ready` = !`wb_valid` && !`muu_valid`.
- A transfer happens on valid && ready.
- `wb_valid` high while `wb_stall` is 1 is a protocol error; the WB request is dropped.
- Winner drives the port registers on the next edge:
  - WB passes `wb_mode`, `wb_muu_we` and `wb_movn` through unchanged.
  - MUU and DBG drive `write_enable`=01 with both condition flags 0.
  - No winner drives `write_enable`=00; `write_reg`/`write_data` hold their last value.
- Destination register 0 is accepted and handshaken, but drives `write_enable`=00.
- Starvation counter `starve_cnt`:
  - Increments each cycle `muu_valid` is 1 without a MUU transfer.
  - Clears on a MUU transfer, or when `muu_valid` is 0.
  - `wb_stall` is registered as (`starve_cnt` == STARVE_LIMIT-1 && increment); it is high on the cycle after the limit is reached.
  - `wb_stall` deasserts on the edge after the MUU transfer.
- DBG has no starvation guarantee.

## Timing
- Request accepted in cycle N: port outputs valid in cycle N+1; bank commits at the end of N+1; value readable in N+2.
- No internal forwarding.
- Back-to-back grants every cycle; throughput 1 write/cycle.
- Reset values: all port outputs 0 (`write_enable`=00), `wb_stall`=0, `starve_cnt`=0, busy mask all 0, `hazard1`/`hazard2`=0.
- Reset mid-request: nothing is retained, and requesters must re-present.

## Configuration
- `REGFILE_SCOREBOARD_EN` defined:
  - 32-bit busy mask. Bit r is set on the edge where `muu_issue` is 1 and `muu_issue_reg`=r≠0.
  - Bit r is cleared on the edge where a MUU transfer to r is accepted.
  - If set and clear target the same register on the same edge, set wins.
  - `hazardK` = busy[`rd_regK`], combinational; register 0 never reports a hazard.
- Undefined: no mask; `muu_issue` is ignored; `hazard1`/`hazard2` are tied to 0.

## Test plan
- Reset, then WB write r8=0x1234 mode 01 → next cycle `write_reg`=8, `write_data`=0x1234, `write_enable`=01; bank t0 reads 0x1234 one cycle later.
- WB, MUU (r9=0xAA) and DBG (r10=0xBB) all valid in one cycle → WB wins; MUU writes the next free cycle, then DBG; `dbg_ready` stays 0 while MUU is valid.
- STARVE_LIMIT=4:
  - WB valid every cycle and MUU valid → `wb_stall`=1 after the 4th waiting cycle.
  - MUU is granted in the stall cycle.
  - `wb_stall`=0 on the following cycle.
- WB r0=0xFFFF mode 01 → handshake completes, `write_enable`=00, bank r0 remains 0.
- WB mode 10 with `wb_movn`=1 and r11 → `write_enable`=10 and `movn`=1 on the port; with both flags 0, r11 is unchanged.
- With `REGFILE_SCOREBOARD_EN`:
  - `muu_issue` r12 → `hazard1`=1 when `rd_reg1`=12.
  - MUU result r12 accepted together with a new `muu_issue` r12 → hazard stays 1.
  - Result alone → 0 next cycle.
